// File: rtl/uart_encoder_if.sv
// rtl/uart_encoder_if.sv - byte-stream input and serial-line output bundle for uart_encoder
interface uart_encoder_if;
    logic [7:0] data_i;
    logic       valid_i;
    logic       ready_o;
    logic       tx_o;
    logic       busy_o;

    modport master (
        output data_i,
        output valid_i,
        input  ready_o,
        input  tx_o,
        input  busy_o
    );

    modport slave (
        input  data_i,
        input  valid_i,
        output ready_o,
        output tx_o,
        output busy_o
    );
endinterface

// File: rtl/uart_encoder.sv
// rtl/uart_encoder.sv - FIFO-buffered 8N1 UART transmitter (8E1 when UART_ENCODER_PARITY_EN is defined)
module uart_encoder #(
    parameter int CLK_DIV = 271,
    parameter int FIFO_AW = 3
) (
    input  logic           clk,
    input  logic           rst,
    uart_encoder_if.slave  bus
);

    localparam int             BW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int             DEPTH     = 1 << FIFO_AW;
    localparam logic [BW-1:0]  BAUD_LAST = BW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_ENCODER_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [7:0]          r_mem [DEPTH];
    logic [FIFO_AW:0]    r_wr_ptr;
    logic [FIFO_AW:0]    r_rd_ptr;
    logic [7:0]          r_shift;
    logic [BW-1:0]       r_baud;
    logic [2:0]          r_bit;
    logic                r_tx;
`ifdef UART_ENCODER_PARITY_EN
    logic                r_parity;
`endif

    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_baud_last;
    logic                w_tx_next;
    logic [7:0]          w_head;

    // Extra pointer MSB distinguishes full from empty when the address bits match.
    assign w_full      = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                         (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);
    assign w_empty     = (r_wr_ptr == r_rd_ptr);
    assign w_push      = bus.valid_i && !w_full;
    assign w_head      = r_mem[r_rd_ptr[FIFO_AW-1:0]];
    assign w_baud_last = (r_baud == BAUD_LAST);

    assign bus.ready_o = !w_full;
    assign bus.busy_o  = (r_state != S_IDLE) || !w_empty;
    assign bus.tx_o    = r_tx;

    // Next state, FIFO pop and the line level for the next cycle.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_tx_next    = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                w_tx_next = 1'b0;
                if (w_baud_last) begin
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                w_tx_next = r_shift[0];
                if (w_baud_last && (r_bit == 3'd7)) begin
`ifdef UART_ENCODER_PARITY_EN
                    w_state_next = S_PARITY;
`else
                    w_state_next = S_STOP;
`endif
                end
            end
`ifdef UART_ENCODER_PARITY_EN
            S_PARITY: begin
                w_tx_next = r_parity;
                if (w_baud_last) begin
                    w_state_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                w_tx_next = 1'b1;
                if (w_baud_last) begin
                    // Chain straight into the next start bit when more data waits.
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_state_next = S_START;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // FIFO storage; contents need no reset because the pointers gate every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[FIFO_AW-1:0]] <= bus.data_i;
        end
    end

    // State, pointers, baud/bit counters, shifter and the registered line output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_shift  <= '0;
            r_baud   <= '0;
            r_bit    <= '0;
            r_tx     <= 1'b1;
`ifdef UART_ENCODER_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            r_tx    <= w_tx_next;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_shift  <= w_head;
`ifdef UART_ENCODER_PARITY_EN
                r_parity <= ^w_head;
`endif
            end
            if ((r_state == S_IDLE) || w_baud_last) begin
                r_baud <= '0;
            end else begin
                r_baud <= r_baud + 1'b1;
            end
            if (r_state == S_START) begin
                r_bit <= '0;
            end
            if ((r_state == S_DATA) && w_baud_last) begin
                r_shift <= r_shift >> 1;
                r_bit   <= r_bit + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_encoder.sv
// tb/tb_uart_encoder.sv - scoreboard bench for uart_encoder
`timescale 1ns/1ps
module tb_uart_encoder;

    localparam int CLK_DIV = 4;
    localparam int FIFO_AW = 3;
`ifdef UART_ENCODER_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CLK_DIV;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_encoder_if bus ();

    uart_encoder #(
        .CLK_DIV (CLK_DIV),
        .FIFO_AW (FIFO_AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int         n_checks    = 0;
    int         n_pass      = 0;
    int         frames_seen = 0;
    int         last_gap    = 0;
    logic       mon_active  = 1'b0;
    logic [7:0] exp_q [$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual %0d required %0d", name, act, exp);
    endtask

    // Monitor: decodes frames off the line and checks them against the scoreboard.
    initial begin : monitor
        logic             prev;
        logic             val;
        logic             stable;
        int               cnt;
        int               idx;
        int               gap;
        logic [NBITS-1:0] bits;
        logic [7:0]       d;
        logic [7:0]       e;
        prev = 1'b1; val = 1'b0; stable = 1'b1;
        cnt = 0; idx = 0; gap = 0; bits = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_active = 1'b0;
                prev       = 1'b1;
                gap        = 0;
            end else begin
                if (!mon_active) begin
                    if (prev && !bus.tx_o) begin
                        mon_active = 1'b1;
                        idx = 0; cnt = 1; val = 1'b0; stable = 1'b1;
                        last_gap = gap;
                        gap = 0;
                    end else begin
                        gap++;
                    end
                end else begin
                    if (cnt == 0) begin
                        val    = bus.tx_o;
                        stable = 1'b1;
                    end else if (bus.tx_o !== val) begin
                        stable = 1'b0;
                    end
                    cnt++;
                end
                if (mon_active && cnt == CLK_DIV) begin
                    check("bit_stable", stable, 1);
                    bits[idx] = val;
                    idx++;
                    cnt = 0;
                    if (idx == NBITS) begin
                        mon_active = 1'b0;
                        frames_seen++;
                        d = bits[8:1];
                        check("start_bit", bits[0], 0);
                        check("stop_bit", bits[NBITS-1], 1);
`ifdef UART_ENCODER_PARITY_EN
                        check("parity_bit", bits[9], ^d);
`endif
                        check("frame_expected", exp_q.size() > 0, 1);
                        if (exp_q.size() > 0) begin
                            e = exp_q.pop_front();
                            check("frame_data", d, e);
                        end
                    end
                end
                prev = bus.tx_o;
            end
        end
    end

    task automatic push(input logic [7:0] d, input bit expect_tx);
        int t;
        t = 0;
        @(negedge clk);
        bus.data_i  = d;
        bus.valid_i = 1'b1;
        while (!bus.ready_o && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("push_ready", bus.ready_o, 1);
        @(posedge clk);
        if (expect_tx) exp_q.push_back(d);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk);
        while ((bus.busy_o || mon_active || exp_q.size() != 0) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("drain_in_time", t < 3000, 1);
    endtask

    task automatic frame_timing(input logic [7:0] d);
        push(d, 1'b1);
        @(negedge clk);
        bus.valid_i = 1'b0;
        check("busy_after_push", bus.busy_o, 1);
        check("tx_high_at_pop", bus.tx_o, 1);
        @(negedge clk);
        check("tx_high_in_start", bus.tx_o, 1);
        @(negedge clk);
        check("tx_start_latency", bus.tx_o, 0);
        repeat (FRAME - 2) @(negedge clk);
        check("busy_last_stop", bus.busy_o, 1);
        @(negedge clk);
        check("busy_falls", bus.busy_o, 0);
        wait_idle();
    endtask

    task automatic mid_reset(input logic [7:0] d);
        int lows;
        push(d, 1'b0);
        @(negedge clk);
        bus.valid_i = 1'b0;
        repeat (19) @(negedge clk);
        check("tx_is_bit3", bus.tx_o, d[3]);
        rst = 1'b1;
        @(negedge clk);
        check("reset_tx_next", bus.tx_o, 1);
        @(negedge clk);
        rst = 1'b0;
        check("reset_ready", bus.ready_o, 1);
        check("reset_busy", bus.busy_o, 0);
        lows = 0;
        repeat (20) begin
            @(negedge clk);
            if (!bus.tx_o) lows++;
        end
        check("reset_tx_quiet", lows, 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1);
    end

    initial begin : stimulus
        int acc;
        bus.valid_i = 1'b0;
        bus.data_i  = 8'h00;
        rst         = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_tx", bus.tx_o, 1);
        check("rst_ready", bus.ready_o, 1);
        check("rst_busy", bus.busy_o, 0);

        frame_timing(8'h55);
        frame_timing(8'h07);

        push(8'hA5, 1'b1);
        push(8'h3C, 1'b1);
        @(negedge clk);
        bus.valid_i = 1'b0;
        wait_idle();
        check("b2b_gap", last_gap, 0);

        acc = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            bus.data_i  = 8'h10 + 8'(i);
            bus.valid_i = 1'b1;
            check("fill_ready", bus.ready_o, (i < 9) ? 1 : 0);
            if (bus.ready_o) begin
                acc++;
                @(posedge clk);
                exp_q.push_back(8'h10 + 8'(i));
            end else begin
                @(posedge clk);
            end
        end
        @(negedge clk);
        bus.valid_i = 1'b0;
        check("fill_accepted", acc, 9);
        check("fill_ready_low", bus.ready_o, 0);
        wait_idle();

        mid_reset(8'hFF);
        frame_timing(8'h00);
        mid_reset(8'h00);
        frame_timing(8'hC3);

        check("frames_seen", frames_seen, 15);
        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_encoder.md
# uart_encoder

UART transmit encoder: the drive-side counterpart of the bench UART decoder. It accepts bytes on a valid/ready handshake, buffers them in a small FIFO and serialises them as 8N1 frames, LSB first, onto a single line at a fixed integer baud divisor. It drives the SoC's `uart0_srx_pad_i` in simulation and also serves as a synthesizable console source for debug builds.

## Interface
Parameters:
- `CLK_DIV`, 271: clock cycles per bit (31.25 MHz / 115200). Must be ≥ 2.
- `FIFO_AW`, 3: FIFO address width; depth = 2**FIFO_AW = 8 entries.

Ports:
- `clk`  in  1: single clock; every register is on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `data_i`  in  8: byte to transmit.
- `valid_i`  in  1: `data_i` is valid.
- `ready_o`  out  1: FIFO can accept a byte; equals `!full`.
- `tx_o`  out  1: serial line, idles high; registered output.
- `busy_o`  out  1: high when the FSM is not in IDLE or the FIFO is non-empty.

## Operation
- **Write.** A byte is pushed when `valid_i && ready_o` at a rising edge. If `valid_i` is high while the FIFO is full, the byte is not accepted. The source must hold `data_i` until accepted.
- **FSM states.** IDLE, START, DATA, PARITY (present only when configured in), STOP.
- **IDLE.** If the FIFO is non-empty, pop the head into the shift register, go to START and clear the baud counter. Otherwise stay in IDLE.
- **START.** `tx_o` = 0 for `CLK_DIV` cycles, then go to DATA with bit counter = 0.
- **DATA.** `tx_o` = shift[0]. After `CLK_DIV` cycles, shift right and increment the bit counter. After bit 7, go to PARITY (if enabled) or STOP.
- **PARITY.** `tx_o` = even parity (XOR of the 8 data bits) for `CLK_DIV` cycles, then go to STOP.
- **STOP.** `tx_o` = 1 for `CLK_DIV` cycles. At the last cycle:
  - If the FIFO is non-empty, pop and go directly to START, so frames run back-to-back with no extra idle.
  - Otherwise go to IDLE.
- **Counters.** Baud counter width is `$clog2(CLK_DIV)`; it counts 0..`CLK_DIV`-1 and wraps. Bit counter is 3 bits. FIFO pointers are `FIFO_AW`+1 bits: full when the MSBs differ and the remaining bits are equal; empty when all bits are equal.
- **Simultaneous push and pop.**
  - Non-full FIFO: both happen in the same cycle and the occupancy is unchanged.
  - Full FIFO: the push is refused even if a pop occurs in the same cycle, because `ready_o` depends only on the registered full flag.
- **Reset.** Synchronous reset, including mid-frame:
  - FIFO is flushed and the FSM goes to IDLE.
  - `tx_o` = 1 on the cycle after `rst` is sampled high, so any partial frame is truncated.
  - Outputs after reset: `tx_o`=1, `ready_o`=1, `busy_o`=0.

## Timing
- **Latency.** A byte pushed at edge N into an empty FIFO with the FSM in IDLE:
  - is popped at edge N+1;
  - `tx_o` falls at edge N+2.
- **Frame length.** 10·`CLK_DIV` cycles, or 11·`CLK_DIV` with parity. Back-to-back frames have zero idle cycles between them.
- **`ready_o`.**
  - Falls the cycle after the push that fills the FIFO.
  - Rises the cycle after the first pop from a full FIFO.
- **`busy_o`.**
  - Rises the cycle after the first push.
  - Falls in the cycle after the final STOP completes with the FIFO empty.
- **Output timing.** `tx_o` transitions are glitch-free: the output is a flop output with no combinational path.

## Configuration
- `UART_ENCODER_PARITY_EN`, defined: the PARITY state is compiled in. Each frame is 8E1, 11 bits.
- `UART_ENCODER_PARITY_EN`, undefined: the PARITY state and its logic are absent. Each frame is 8N1, 10 bits.

## Test plan
- **Reset.** Assert `rst` for 2 cycles → `tx_o`=1, `ready_o`=1, `busy_o`=0 on the following cycle.
- **Single byte** (`CLK_DIV`=4). Push 0x55 → `tx_o` falls 2 cycles later, then shows 0,1,0,1,0,1,0,1,0,1, each level held exactly 4 cycles. `busy_o` drops 1 cycle after the stop bit ends.
- **Parity** (`CLK_DIV`=4, parity enabled). Push 0x07 → data bits 1,1,1,0,0,0,0,0, then parity bit 1, then stop bit; 44 cycles from start-bit edge to stop-bit end.
- **Back-to-back** (`CLK_DIV`=4). Push 0xA5 then 0x3C on consecutive cycles → the second start bit begins on the cycle immediately after the first frame's 4-cycle stop bit.
- **Full FIFO** (`CLK_DIV`=8, `FIFO_AW`=3). Hold `valid_i` high for 12 cycles with incrementing data → exactly 9 bytes accepted (8 stored + 1 popped into the shifter) and `ready_o` low. All 9 bytes are transmitted in order.
- **Mid-frame reset.** Push 0xFF, then assert `rst` during DATA bit 3 → `tx_o`=1 the next cycle and stays high. A subsequent push of 0x00 produces a clean full frame.
